pkt_dispatcher: RTL and testbench
=================================

# pkt_dispatcher

- Drives a `proc_base` instance from the packet side, which is the initiator end of its `start_i`/`pkt_hdr_i`/`ready_o` handshake.
- Takes packets in as a byte stream and assembles the header into a zero-padded buffer of `HDR_MAX_LEN` bytes.
- Raises the start strobe and holds it until the processor reports completion, then releases it.
- Streams the stored header bytes downstream and keeps packet, truncation and timeout counters.

## Interface
Parameters:
- HDR_MAX_LEN, `` `HDR_MAX_LEN ``, header buffer depth in bytes; extra bytes are dropped.
- TIMEOUT, 1024, maximum WAIT cycles before the run is abandoned.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  input byte valid.
- in_data_i  in  `` `BYTE_BUS ``  input byte.
- in_last_i  in  1  final byte of packet.
- in_ready_o  out  1  input byte accepted when valid&ready.
- proc_start_o  out  1  start strobe to processor `start_i`.
- proc_pkt_hdr_o  out  `` `BYTE_BUS `` x [0:HDR_MAX_LEN-1]  header buffer to processor `pkt_hdr_i`.
- proc_ready_i  in  1  processor `ready_o`.
- out_valid_o  out  1  output byte valid.
- out_data_o  out  `` `BYTE_BUS ``  output byte.
- out_last_o  out  1  final output byte.
- out_ready_i  in  1  downstream accept.
- pkt_cnt_o  out  32  packets fully emitted.
- trunc_cnt_o  out  16  packets longer than HDR_MAX_LEN.
- timeout_cnt_o  out  16  runs abandoned by the timeout.

## Operation
States and transitions:
- **IDLE**:
  - in_ready_o=1.
  - On the first accepted byte: write buf[0], zero buf[1..HDR_MAX_LEN-1], set len=1.
  - Go to KICK if in_last_i, else RECV.
- **RECV**:
  - in_ready_o=1.
  - Each accepted byte is written to buf[len] and len increments.
  - When in_last_i: go to KICK.
  - Else if len reaches HDR_MAX_LEN: go to DROP.
- **DROP**:
  - in_ready_o=1; accepted bytes are discarded.
  - On last: trunc_cnt_o++, go to KICK.
  - A packet of exactly HDR_MAX_LEN bytes is not truncated.
- **KICK**:
  - Set proc_start_o=1 and ignore proc_ready_i for this one cycle, because it may still be high from the previous run.
  - Go to WAIT.
- **WAIT**:
  - proc_start_o=1; wait counter increments each cycle.
  - proc_ready_i=1: drop proc_start_o, go to EMIT with idx=0.
  - Counter reaches TIMEOUT: drop proc_start_o, timeout_cnt_o++, go to IDLE; the packet is discarded.
- **EMIT**:
  - out_valid_o=1, out_data_o=buf[idx], out_last_o=(idx==len-1).
  - On handshake: idx++.
  - On the last handshake: pkt_cnt_o++, go to IDLE.

Data and flow rules:
- in_ready_o=0 in KICK/WAIT/EMIT; the buffer is never written while proc_start_o is high.
- proc_pkt_hdr_o is held stable from KICK until the next IDLE byte is accepted.
- len is 16 bits and saturates at HDR_MAX_LEN.
- Counters wrap modulo 2^width.
- out_data_o and out_last_o are stable while out_valid_o&!out_ready_i.

## Timing
- Reset values (applied asynchronously):
  - State IDLE; in_ready_o=0 during reset, 1 from the first cycle after release.
  - proc_start_o=0, out_valid_o=0, out_last_o=0, out_data_o=0.
  - Buffer all zeros; all counters 0.
- Input throughput: 1 byte/cycle.
- Start latency: the last byte is accepted at edge E; proc_start_o is high in the cycle after E.
- Ready sampling:
  - proc_ready_i is first sampled at the end of the second start cycle (the WAIT entry cycle).
  - proc_ready_i=1 sampled at edge R gives proc_start_o=0 and out_valid_o=1 from R.
- Start spacing: proc_start_o stays low for at least 2 consecutive cycles between runs. This is guaranteed by EMIT (≥1 cycle) plus the IDLE byte acceptance, and gives the processor its DONE→FREE transition.
- Processor reconfiguration: if the processor delays a start because of a reconfiguration strobe, proc_start_o stays held; no special handling.
- Timeout: proc_start_o is high for exactly TIMEOUT+1 cycles (KICK + TIMEOUT WAIT cycles).
- Reset mid-operation: proc_start_o falls immediately; the in-flight packet is lost with no output.

## Test plan
- **Basic run:** 20-byte packet 0x00..0x13; model raises proc_ready_i 5 cycles after start.
  - proc_start_o high from the cycle after the last byte until ready.
  - proc_pkt_hdr_o[0..19]=0x00..0x13, remaining bytes 0.
  - Output is 20 bytes with out_last_o on 0x13; pkt_cnt_o=1.
- **Stale ready:** proc_ready_i held high across KICK, then low for 3 cycles, then high.
  - The dispatcher ignores the KICK-cycle value and releases start only on the later high.
- **Truncation:** HDR_MAX_LEN+10 bytes.
  - in_ready_o high for all bytes; buffer holds the first HDR_MAX_LEN.
  - trunc_cnt_o=1; HDR_MAX_LEN bytes emitted.
  - An exact HDR_MAX_LEN packet leaves trunc_cnt_o unchanged.
- **Timeout:** TIMEOUT=16, processor never ready.
  - proc_start_o high for 17 cycles; timeout_cnt_o=1.
  - No out_valid_o; the next packet is accepted normally.
- **Backpressure:** out_ready_i toggles 1,0,0,1 during emit.
  - Bytes are neither repeated nor skipped; data is stable while stalled.
- **Reset mid-run:** rst low during WAIT.
  - proc_start_o=0 and counters 0 without waiting for a clock edge.
  - After release, a 1-byte packet completes with pkt_cnt_o=1.

Source files
------------

// File: rtl/pkt_dispatcher.sv
// pkt_dispatcher
//   Collects a packet from a byte stream into a zero-padded header buffer,
//   hands the buffer to a downstream processor with a start/ready handshake,
//   then replays the stored header bytes on an output byte stream.
//
// Ports
//   clk            : single clock, rising edge
//   rst            : asynchronous reset, active-low
//   in_valid_i     : input byte valid
//   in_data_i      : input byte
//   in_last_i      : final byte of packet
//   in_ready_o     : input byte accepted when in_valid_i & in_ready_o
//   proc_start_o   : start strobe to the processor, held until it is ready
//   proc_pkt_hdr_o : header buffer presented to the processor
//   proc_ready_i   : processor completion
//   out_valid_o    : output byte valid
//   out_data_o     : output byte
//   out_last_o     : final output byte
//   out_ready_i    : downstream accept
//   pkt_cnt_o      : packets fully emitted
//   trunc_cnt_o    : packets longer than HDR_MAX_LEN
//   timeout_cnt_o  : runs abandoned because the processor never answered
module pkt_dispatcher #(
  parameter int DATA_W      = 8,
  parameter int HDR_MAX_LEN = 32,
  parameter int TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic              proc_start_o,
  output logic [DATA_W-1:0] proc_pkt_hdr_o [0:HDR_MAX_LEN-1],
  input  logic              proc_ready_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  input  logic              out_ready_i,
  output logic [31:0]       pkt_cnt_o,
  output logic [15:0]       trunc_cnt_o,
  output logic [15:0]       timeout_cnt_o
);

  localparam int IDX_W  = (HDR_MAX_LEN > 1) ? $clog2(HDR_MAX_LEN) : 1;
  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [15:0]       LEN_MAX   = 16'(HDR_MAX_LEN);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_DROP, S_KICK, S_WAIT, S_EMIT
  } state_t;

  state_t              state_q;
  logic                in_ready_q;
  logic                start_q;
  logic                out_valid_q;
  logic                out_last_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [DATA_W-1:0]   buf_q [0:HDR_MAX_LEN-1];
  logic [15:0]         len_q;
  logic [IDX_W-1:0]    idx_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [31:0]         pkt_cnt_q;
  logic [15:0]         trunc_cnt_q;
  logic [15:0]         timeout_cnt_q;

  logic                accept;
  logic [IDX_W-1:0]    idx_next;

  assign accept   = in_valid_i & in_ready_q;
  assign idx_next = idx_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b0;
      start_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      wcnt_q        <= '0;
      pkt_cnt_q     <= '0;
      trunc_cnt_q   <= '0;
      timeout_cnt_q <= '0;
      for (int i = 0; i < HDR_MAX_LEN; i++) buf_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            // A new packet starts: clear the stale tail so short headers are zero-padded.
            buf_q[0] <= in_data_i;
            for (int i = 1; i < HDR_MAX_LEN; i++) buf_q[i] <= '0;
            len_q <= 16'd1;
            if (in_last_i) begin
              state_q    <= S_KICK;
              in_ready_q <= 1'b0;
              start_q    <= 1'b1;
            end else if (LEN_MAX == 16'd1) begin
              state_q <= S_DROP;
            end else begin
              state_q <= S_RECV;
            end
          end
        end
        S_RECV: begin
          if (accept) begin
            buf_q[len_q[IDX_W-1:0]] <= in_data_i;
            if (len_q < LEN_MAX) len_q <= len_q + 16'd1;
            if (in_last_i) begin
              state_q    <= S_KICK;
              in_ready_q <= 1'b0;
              start_q    <= 1'b1;
            end else if (len_q + 16'd1 >= LEN_MAX) begin
              state_q <= S_DROP;
            end
          end
        end
        S_DROP: begin
          if (accept && in_last_i) begin
            trunc_cnt_q <= trunc_cnt_q + 1'b1;
            state_q     <= S_KICK;
            in_ready_q  <= 1'b0;
            start_q     <= 1'b1;
          end
        end
        S_KICK: begin
          // proc_ready_i may still be high from the previous run; not sampled here.
          state_q <= S_WAIT;
          wcnt_q  <= '0;
        end
        S_WAIT: begin
          if (proc_ready_i) begin
            start_q     <= 1'b0;
            state_q     <= S_EMIT;
            out_valid_q <= 1'b1;
            out_data_q  <= buf_q[0];
            out_last_q  <= (len_q == 16'd1);
            idx_q       <= '0;
          end else if (wcnt_q == WCNT_LAST) begin
            start_q       <= 1'b0;
            timeout_cnt_q <= timeout_cnt_q + 1'b1;
            state_q       <= S_IDLE;
            in_ready_q    <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        S_EMIT: begin
          if (out_ready_i) begin
            if (out_last_q) begin
              pkt_cnt_q   <= pkt_cnt_q + 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= S_IDLE;
              in_ready_q  <= 1'b1;
            end else begin
              idx_q      <= idx_next;
              out_data_q <= buf_q[idx_next];
              out_last_q <= (16'(idx_next) == len_q - 16'd1);
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
          start_q    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o     = in_ready_q;
  assign proc_start_o   = start_q;
  assign proc_pkt_hdr_o = buf_q;
  assign out_valid_o    = out_valid_q;
  assign out_data_o     = out_data_q;
  assign out_last_o     = out_last_q;
  assign pkt_cnt_o      = pkt_cnt_q;
  assign trunc_cnt_o    = trunc_cnt_q;
  assign timeout_cnt_o  = timeout_cnt_q;

endmodule

// File: tb/tb_pkt_dispatcher.sv
// Directed bench for pkt_dispatcher: a table of packets with hand-computed
// expectations plus hand-written timeout and reset-mid-run sequences.
module tb_pkt_dispatcher;

  localparam int HLEN = 32;
  localparam int TOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_last, in_ready;
  logic [7:0] in_data;
  logic       proc_start, proc_ready;
  logic [7:0] hdr [0:HLEN-1];
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;
  logic [31:0] pkt_cnt;
  logic [15:0] trunc_cnt, timeout_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pkt_dispatcher #(.DATA_W(8), .HDR_MAX_LEN(HLEN), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_last_i(in_last), .in_ready_o(in_ready),
    .proc_start_o(proc_start), .proc_pkt_hdr_o(hdr), .proc_ready_i(proc_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last), .out_ready_i(out_ready),
    .pkt_cnt_o(pkt_cnt), .trunc_cnt_o(trunc_cnt), .timeout_cnt_o(timeout_cnt)
  );

  typedef struct {
    int n;          // packet length in bytes
    int base;       // byte i carries base+i
    int d;          // ready raised in start cycle d (0 = never)
    bit stale;      // ready high across the last byte and KICK
    bit bp;         // out_ready pattern 1,0,0,1 repeating
    int exp_start;  // cycles proc_start_o is high
    int exp_emit;   // bytes emitted
    int exp_pkt;
    int exp_trunc;
    int exp_tout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_pkt(input int n, input int base, output int rdy_err, output int early);
    rdy_err = 0;
    early   = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b1) rdy_err++;
      if (proc_start !== 1'b0) early++;
      in_valid = 1'b1;
      in_data  = 8'(base + i);
      in_last  = (i == n - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_proc(input int d, input bit stale, output int scyc, output int ov);
    int guard = 0;
    scyc = 0;
    ov   = 0;
    while (proc_start === 1'b1 && guard < 200) begin
      scyc++;
      proc_ready = (stale && scyc == 1) || (d > 0 && scyc >= d);
      if (out_valid !== 1'b0) ov++;
      @(negedge clk);
      guard++;
    end
    proc_ready = 1'b0;
  endtask

  task automatic collect(input int exp_n, input int base, input bit bp,
                         output int got, output int derr, output int lerr, output int serr);
    int cyc = 0;
    bit done = 1'b0;
    bit prev_stall = 1'b0;
    bit r;
    logic [7:0] pd;
    logic pl;
    got = 0; derr = 0; lerr = 0; serr = 0;
    while (!done && cyc < 400) begin
      if (prev_stall && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl)) serr++;
      r = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      out_ready = r;
      if (out_valid === 1'b1 && r) begin
        if (out_data !== 8'(base + got)) derr++;
        if (out_last !== (got == exp_n - 1)) lerr++;
        got++;
        if (out_last === 1'b1 || got > exp_n + 2) done = 1'b1;
      end
      prev_stall = (out_valid === 1'b1) && !r;
      pd = out_data;
      pl = out_last;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int rdy_err, early, hdr_err, scyc, ov, got, derr, lerr, serr;
    logic [7:0] e;
    proc_ready = v.stale;
    send_pkt(v.n, v.base, rdy_err, early);
    check("in_ready_per_byte_errs", rdy_err, 0);
    check("start_before_last_errs", early, 0);
    check("start_latency", proc_start, 1);
    check("in_ready_low_in_kick", in_ready, 0);
    hdr_err = 0;
    for (int i = 0; i < HLEN; i++) begin
      e = (i < v.n) ? 8'(v.base + i) : 8'h00;
      if (hdr[i] !== e) hdr_err++;
    end
    check("hdr_buffer_errs", hdr_err, 0);
    run_proc(v.d, v.stale, scyc, ov);
    check("start_cycles", scyc, v.exp_start);
    check("no_valid_while_start", ov, 0);
    if (v.exp_emit > 0) begin
      check("valid_at_release", out_valid, 1);
      collect(v.exp_emit, v.base, v.bp, got, derr, lerr, serr);
      check("emit_count", got, v.exp_emit);
      check("emit_data_errs", derr, 0);
      check("emit_last_errs", lerr, 0);
      check("stall_stability_errs", serr, 0);
      check("valid_after_last", out_valid, 0);
    end else begin
      check("no_emit_after_timeout", out_valid, 0);
      check("in_ready_after_timeout", in_ready, 1);
    end
    check("pkt_cnt", pkt_cnt, v.exp_pkt);
    check("trunc_cnt", trunc_cnt, v.exp_trunc);
    check("timeout_cnt", timeout_cnt, v.exp_tout);
  endtask

  vec_t vecs [7];
  vec_t hv;
  int zero_err;

  initial begin
      //      n    base  d  st bp start emit pkt trunc tout
    vecs[0] = '{20, 8'h00, 5, 0, 0, 5, 20, 1, 0, 0};  // basic run
    vecs[1] = '{42, 8'h40, 2, 0, 0, 2, 32, 2, 1, 0};  // truncation
    vecs[2] = '{20, 8'h80, 3, 0, 0, 3, 20, 3, 1, 0};  // zero padding after long packet
    vecs[3] = '{32, 8'hA0, 1, 0, 0, 2, 32, 4, 1, 0};  // exact length, KICK ready ignored
    vecs[4] = '{4,  8'h10, 5, 1, 1, 5, 4,  5, 1, 0};  // stale ready + backpressure
    vecs[5] = '{1,  8'h77, 2, 0, 1, 2, 1,  6, 1, 0};  // single byte
    vecs[6] = '{7,  8'h30, 3, 0, 1, 3, 7,  7, 1, 0};  // backpressure

    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    proc_ready = 1'b0; out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_start", proc_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_trunc_cnt", trunc_cnt, 0);
    check("rst_timeout_cnt", timeout_cnt, 0);
    zero_err = 0;
    for (int i = 0; i < HLEN; i++) if (hdr[i] !== 8'h00) zero_err++;
    check("rst_hdr_zero_errs", zero_err, 0);
    rst = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1);

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Timeout: processor never answers; start must be high KICK + 16 WAIT cycles.
    hv = '{5, 8'h50, 0, 0, 0, 17, 0, 7, 1, 1};
    run_vec(hv);
    // Next packet after a timeout goes through normally.
    hv = '{3, 8'h60, 2, 0, 0, 2, 3, 8, 1, 1};
    run_vec(hv);

    // Reset in the middle of WAIT.
    send_pkt(2, 8'h90, zero_err, zero_err);
    check("mid_start_high", proc_start, 1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_start", proc_start, 0);
    check("mid_rst_pkt_cnt", pkt_cnt, 0);
    check("mid_rst_trunc_cnt", trunc_cnt, 0);
    check("mid_rst_timeout_cnt", timeout_cnt, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_hdr0", hdr[0], 0);
    @(negedge clk);
    rst = 1'b1;
    hv = '{1, 8'hEE, 2, 0, 0, 2, 1, 1, 0, 0};
    run_vec(hv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "bench time limit expired");
  end

endmodule
